// File: rtl/laser_aurora_pkg.sv
// Shared types and frame field helpers for the aurora TX framer.
package laser_aurora_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA,
    ST_TAIL,
    ST_DRAIN
  } tx_state_e;

  localparam int LEN_W        = 11;
  localparam int HDR_TAG_LSB  = 16;
  localparam int TAIL_SEQ_LSB = 16;

  function automatic logic [31:0] mk_header(input logic [15:0] tag, input logic [LEN_W-1:0] len);
    return (32'(tag) << HDR_TAG_LSB) | 32'(len);
  endfunction

  function automatic logic [31:0] mk_tail(input logic [15:0] seq, input logic [15:0] chk);
    return (32'(seq) << TAIL_SEQ_LSB) | 32'(chk);
  endfunction

  function automatic logic [15:0] fold16(input logic [31:0] w);
    return w[31:16] ^ w[15:0];
  endfunction

endpackage

// File: rtl/laser_aurora_tx_framer_skid.sv
// 2-entry in-order buffer; entry 0 is always the head.
module tx_skid_buf #(
  parameter int W = 32
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem;

  // Pop is only issued with occ != 0, push only with room, so no overflow case exists.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem <= '0;
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          mem[occ[0]] <= din;
          occ         <= occ + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ[1]) begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end else begin
            mem[0] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = mem[0];

endmodule

// File: rtl/laser_aurora_tx_framer.sv
// Drains the laser-word FIFO into header/data/tail frames on the Aurora TX stream,
// aborting and draining the frame's remaining words if the channel drops.
module laser_aurora_tx_framer
  import laser_aurora_pkg::*;
#(
  parameter real         TCQ         = 0.1,
  parameter int          BURST_LEN   = 64,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [15:0] FRAME_HEAD  = 16'h55AA
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        channel_up_i,
  output logic        fifo_rd_en_o,
  input  logic [31:0] fifo_dout_i,
  input  logic        fifo_empty_i,
  input  logic [10:0] fifo_rd_count_i,
  output logic [31:0] m_axi_tx_tdata_o,
  output logic        m_axi_tx_tvalid_o,
  output logic        m_axi_tx_tlast_o,
  input  logic        m_axi_tx_tready_i,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] abort_cnt_o
);
  localparam int               TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LEN_W-1:0] BURST = LEN_W'(BURST_LEN);
  localparam logic [TW-1:0]    TMO   = TW'(TIMEOUT_CYC);

  // Registers are modelled with zero delay; TCQ only exists for the legacy sim flow.
  if (TCQ < 0.0) begin : g_tcq_unused
  end

  tx_state_e        state, state_nxt;
  logic [LEN_W-1:0] len, req_cnt, rem, start_len;
  logic [TW-1:0]    timer;
  logic [15:0]      chk, seq;
  logic             rd_inflight, full_burst, start, have_word, xfer, room, want;
  logic             skid_push, skid_pop, skid_flush;
  logic [1:0]       skid_occ;
  logic [31:0]      skid_dout, cur_word;

  assign full_burst = fifo_rd_count_i >= BURST;
  assign start      = enable_i && channel_up_i &&
                      (full_burst || (!fifo_empty_i && timer == TMO));
  assign start_len  = full_burst ? BURST :
                      (fifo_rd_count_i == '0) ? LEN_W'(1) : fifo_rd_count_i;

  // A word popped last cycle is on fifo_dout now and bypasses the empty skid buffer.
  assign have_word  = (skid_occ != 2'd0) || rd_inflight;
  assign cur_word   = (skid_occ != 2'd0) ? skid_dout : fifo_dout_i;

  always_comb begin
    m_axi_tx_tvalid_o = 1'b0;
    m_axi_tx_tlast_o  = 1'b0;
    m_axi_tx_tdata_o  = '0;
    unique case (state)
      ST_HEAD: begin
        m_axi_tx_tvalid_o = channel_up_i;
        m_axi_tx_tdata_o  = mk_header(FRAME_HEAD, len);
      end
      ST_DATA: begin
        m_axi_tx_tvalid_o = channel_up_i && have_word;
        m_axi_tx_tdata_o  = cur_word;
      end
      ST_TAIL: begin
        m_axi_tx_tvalid_o = channel_up_i;
        m_axi_tx_tlast_o  = 1'b1;
        m_axi_tx_tdata_o  = mk_tail(seq, chk);
      end
      default: ;
    endcase
  end

  assign xfer = m_axi_tx_tvalid_o && m_axi_tx_tready_i;

  assign room = ({1'b0, skid_occ} + {2'b0, rd_inflight}) < 3'd2;
  assign want = (req_cnt < len) && !fifo_empty_i;
  assign fifo_rd_en_o = (((state == ST_HEAD) || (state == ST_DATA)) && room && want) ||
                        ((state == ST_DRAIN) && want);

  assign skid_push  = rd_inflight &&
                      ((state == ST_HEAD) ||
                       ((state == ST_DATA) && !((skid_occ == 2'd0) && xfer)));
  assign skid_pop   = (state == ST_DATA) && xfer && (skid_occ != 2'd0);
  assign skid_flush = (state == ST_DRAIN);

  tx_skid_buf #(.W(32)) u_skid (
    .gclk   (clk_i),
    .grst_n (rst_n_i),
    .flush  (skid_flush),
    .push   (skid_push),
    .pop    (skid_pop),
    .din    (fifo_dout_i),
    .dout   (skid_dout),
    .occ    (skid_occ)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_HEAD;
      ST_HEAD:  if (!channel_up_i) state_nxt = ST_DRAIN;
                else if (xfer)     state_nxt = ST_DATA;
      ST_DATA:  if (!channel_up_i)              state_nxt = ST_DRAIN;
                else if (xfer && rem == LEN_W'(1)) state_nxt = ST_TAIL;
      ST_TAIL:  if (!channel_up_i) state_nxt = ST_DRAIN;
                else if (xfer)     state_nxt = ST_IDLE;
      // Leave only once every word of the frame has been popped and has landed.
      ST_DRAIN: if ((req_cnt == len) && !rd_inflight) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_inflight <= 1'b0;
      len         <= '0;
      req_cnt     <= '0;
      rem         <= '0;
      timer       <= '0;
      chk         <= '0;
      seq         <= '0;
      frame_cnt_o <= '0;
      abort_cnt_o <= '0;
    end else begin
      rd_inflight <= fifo_rd_en_o;
      if (fifo_rd_en_o) req_cnt <= req_cnt + LEN_W'(1);
      if (state == ST_IDLE) begin
        if (start) begin
          len     <= start_len;
          rem     <= start_len;
          req_cnt <= '0;
          chk     <= '0;
          timer   <= '0;
        end else if (fifo_empty_i) begin
          timer <= '0;
        end else if (timer != TMO) begin
          timer <= timer + TW'(1);
        end
      end
      if ((state == ST_DATA) && xfer) begin
        rem <= rem - LEN_W'(1);
        chk <= chk ^ fold16(cur_word);
      end
      if ((state == ST_TAIL) && xfer) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
        seq         <= seq + 16'd1;
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_IDLE)) begin
        abort_cnt_o <= abort_cnt_o + 16'd1;
        seq         <= seq + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_laser_aurora_tx_framer.sv
// Directed + randomized bench: FIFO model, frame-level reference built from the frame rules.
module tb_laser_aurora_tx_framer;
  localparam int BL = 64;
  localparam int TO = 16;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, chan = 1'b0, tready = 1'b1;
  logic        rd_en, empty, tvalid, tlast;
  logic [31:0] dout, tdata;
  logic [10:0] rd_count;
  logic [15:0] frame_cnt, abort_cnt;

  always #5 clk = ~clk;

  laser_aurora_tx_framer #(.BURST_LEN(BL), .TIMEOUT_CYC(TO)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .channel_up_i      (chan),
    .fifo_rd_en_o      (rd_en),
    .fifo_dout_i       (dout),
    .fifo_empty_i      (empty),
    .fifo_rd_count_i   (rd_count),
    .m_axi_tx_tdata_o  (tdata),
    .m_axi_tx_tvalid_o (tvalid),
    .m_axi_tx_tlast_o  (tlast),
    .m_axi_tx_tready_i (tready),
    .frame_cnt_o       (frame_cnt),
    .abort_cnt_o       (abort_cnt)
  );

  int          vecs = 0, miss = 0, pops = 0, rdy_mode = 0;
  longint      cyc = 0, n0 = 0, first_hs = 0, last_hs = 0;
  bit          sb_on = 1'b1, saw_hs = 1'b0, stall_prev = 1'b0;
  logic        last_v = 1'b0;
  logic [31:0] stall_data = '0;
  logic [31:0] fifo_q[$], model_q[$], exp_q[$];
  bit          exp_last_q[$];
  logic [15:0] model_seq = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fifo_sigs();
    empty    = (fifo_q.size() == 0);
    rd_count = 11'(fifo_q.size());
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    model_q.push_back(w);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_word({1'($urandom), 15'h5a69, 16'($urandom)});
    fifo_sigs();
  endtask

  // Reference frame: header, first nsent of len data words, tail only if the frame completes.
  task automatic expect_frame(input int len, input int nsent, input bit full);
    logic [15:0] x;
    logic [31:0] w;
    x = '0;
    exp_q.push_back({16'h55AA, 5'd0, 11'(len)});
    exp_last_q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      w = model_q.pop_front();
      x = x ^ w[31:16] ^ w[15:0];
      if (i < nsent) begin
        exp_q.push_back(w);
        exp_last_q.push_back(1'b0);
      end
    end
    if (full) begin
      exp_q.push_back({model_seq, x});
      exp_last_q.push_back(1'b1);
    end
    model_seq = model_seq + 16'd1;
  endtask

  task automatic tick();
    logic        s_rd, s_v, s_l, el;
    logic [31:0] s_d, e;
    @(negedge clk);
    s_rd = rd_en; s_v = tvalid; s_l = tlast; s_d = tdata;
    last_v = s_v;
    if (stall_prev && chan && rst_n) begin
      chk("stall_hold_valid", 32'(s_v), 32'd1);
      chk("stall_hold_data", s_d, stall_data);
    end
    stall_prev = s_v && !tready;
    stall_data = s_d;
    if (s_v && tready && sb_on) begin
      if (!saw_hs) first_hs = cyc;
      saw_hs  = 1'b1;
      last_hs = cyc;
      chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        el = exp_last_q.pop_front();
        chk("tdata", s_d, e);
        chk("tlast", 32'(s_l), 32'(el));
      end
    end
    if (s_rd) chk("no_overread", 32'(fifo_q.size() > 0), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
    if (s_rd && fifo_q.size() > 0) begin
      dout = fifo_q.pop_front();
      pops++;
    end
    fifo_sigs();
    case (rdy_mode)
      1:       tready = ~tready;
      2:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b1;
    endcase
  endtask

  task automatic run_frame(input int bound);
    for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
    chk("frame_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({tag, "_tlast"}, 32'(tlast), 32'd0);
    chk({tag, "_tdata"}, tdata, 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_abort_cnt"}, 32'(abort_cnt), 32'd0);
  endtask

  initial begin
    dout = '0;
    fifo_sigs();
    enable = 1'b1;
    chan   = 1'b1;
    #12;
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full burst of 64 ascending words with tready held high.
    pops = 0; saw_hs = 1'b0; n0 = cyc;
    for (int i = 0; i < BL; i++) push_word(32'h80005a69 + 32'(i));
    fifo_sigs();
    expect_frame(BL, BL, 1'b1);
    run_frame(300);
    chk("burst_hdr_cycle", 32'(first_hs - n0), 32'd1);
    chk("burst_tail_cycle", 32'(last_hs - n0), 32'd66);
    chk("burst_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("burst_pops", 32'(pops), 32'(BL));

    // Partial frame released by the timeout.
    pops = 0; saw_hs = 1'b0; n0 = cyc;
    push_rand(3);
    expect_frame(3, 3, 1'b1);
    run_frame(100);
    chk("timeout_hdr_cycle", 32'(first_hs - n0), 32'd17);
    chk("timeout_pops", 32'(pops), 32'd3);
    chk("timeout_frame_cnt", 32'(frame_cnt), 32'd2);

    // Backpressure: alternating then random tready.
    for (int m = 1; m <= 2; m++) begin
      rdy_mode = m;
      pops = 0;
      push_rand(BL);
      expect_frame(BL, BL, 1'b1);
      run_frame(1000);
      chk("bp_pops", 32'(pops), 32'(BL));
      rdy_mode = 0;
      tick();
    end
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd4);

    // Channel drop after data word 10.
    pops = 0;
    push_rand(BL);
    expect_frame(BL, 11, 1'b0);
    run_frame(100);
    chan = 1'b0;
    tick();
    chk("drop_tvalid", 32'(last_v), 32'd0);
    for (int i = 0; i < 200 && abort_cnt == 16'd0; i++) tick();
    chk("drop_abort_cnt", 32'(abort_cnt), 32'd1);
    chk("drop_pops", 32'(pops), 32'(BL));
    chk("drop_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("drop_frame_cnt", 32'(frame_cnt), 32'd4);
    chan = 1'b1;
    push_rand(5);
    expect_frame(5, 5, 1'b1);
    run_frame(100);
    chk("recover_frame_cnt", 32'(frame_cnt), 32'd5);

    // enable low holds off a full FIFO.
    enable = 1'b0;
    pops = 0;
    push_rand(BL);
    repeat (60) tick();
    chk("disable_pops", 32'(pops), 32'd0);
    chk("disable_frame_cnt", 32'(frame_cnt), 32'd5);
    enable = 1'b1;
    expect_frame(BL, BL, 1'b1);
    run_frame(300);
    chk("enable_frame_cnt", 32'(frame_cnt), 32'd6);

    // Asynchronous reset mid-DATA.
    sb_on = 1'b0;
    push_rand(BL);
    repeat (20) tick();
    chk("pre_reset_tvalid", 32'(tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    fifo_q.delete();
    model_q.delete();
    model_seq = '0;
    dout = '0;
    fifo_sigs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_on = 1'b1;
    stall_prev = 1'b0;
    push_rand(10);
    expect_frame(10, 10, 1'b1);
    run_frame(100);
    chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
